// File: rtl/sme_rng_lanes.sv
// G parallel xorshift32 lanes that supply guard-share randomness to the masked adder and DOM gadgets.
// Optional macro SME_RNG_RESEED_LIMIT_EN adds a 65536-step use limit that forces a reseed (STALE state).
`timescale 1ns/1ps

module sme_rng_lanes #(
    parameter int D = 3,
    parameter int G = D + D*(D-1)/2,
    parameter int N = 32
) (
    input  logic                g_clk,
    input  logic                g_reset,
    output logic                g_clk_req,
    input  logic                seed_valid,
    output logic                seed_ready,
    input  logic [N-1:0]        seed,
    input  logic                step,
    output logic [G-1:0][N-1:0] rng,
    output logic                rng_valid
);

    localparam logic [1:0] ST_UNSEEDED = 2'd0;
    localparam logic [1:0] ST_WARMUP   = 2'd1;
    localparam logic [1:0] ST_READY    = 2'd2;
`ifdef SME_RNG_RESEED_LIMIT_EN
    localparam logic [1:0] ST_STALE    = 2'd3;
`endif

    localparam logic [N-1:0] LANE_SPREAD = 32'h9E3779B9;

    logic [1:0]          state;
    logic [1:0]          warm_cnt;
    logic [G-1:0][N-1:0] lanes;
    logic                accept;
    logic                advance;
`ifdef SME_RNG_RESEED_LIMIT_EN
    logic [15:0]         step_cnt;
`endif

    function automatic logic [N-1:0] xorshift32(input logic [N-1:0] x);
        logic [N-1:0] y;
        y = x ^ (x << 13);
        y = y ^ (y >> 17);
        y = y ^ (y << 5);
        return y;
    endfunction

    // An all-zero xorshift state is a fixed point, so it is never allowed to load.
    function automatic logic [N-1:0] seed_lane(input logic [N-1:0] s, input int k);
        logic [N-1:0] v;
        v = s ^ (N'(k) * LANE_SPREAD);
        if (v == '0) begin
            v = {{(N-1){1'b0}}, 1'b1};
        end
        return v;
    endfunction

    assign seed_ready = (state != ST_WARMUP);
    assign accept     = seed_valid & seed_ready;
    assign rng_valid  = (state == ST_READY);
    assign g_clk_req  = (state == ST_WARMUP) | step;
    assign advance    = (state == ST_WARMUP) | ((state == ST_READY) & step);
    assign rng        = lanes;

    // NOTE: reset is synchronous and also clears the lane registers, so rng reads 0 until seeded.
    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            state    <= ST_UNSEEDED;
            warm_cnt <= '0;
            lanes    <= '0;
`ifdef SME_RNG_RESEED_LIMIT_EN
            step_cnt <= '0;
`endif
        end else if (accept) begin
            for (int k = 0; k < G; k++) begin
                lanes[k] <= seed_lane(seed, k);
            end
            state    <= ST_WARMUP;
            warm_cnt <= '0;
`ifdef SME_RNG_RESEED_LIMIT_EN
            step_cnt <= '0;
`endif
        end else begin
            if (advance) begin
                for (int k = 0; k < G; k++) begin
                    lanes[k] <= xorshift32(lanes[k]);
                end
            end
            if (state == ST_WARMUP) begin
                warm_cnt <= warm_cnt + 2'd1;
                if (warm_cnt == 2'd3) begin
                    state <= ST_READY;
                end
            end
`ifdef SME_RNG_RESEED_LIMIT_EN
            // Wrap of the step counter marks the 65536th use of this seed.
            if ((state == ST_READY) && step) begin
                step_cnt <= step_cnt + 16'd1;
                if (step_cnt == 16'hFFFF) begin
                    state <= ST_STALE;
                end
            end
`endif
        end
    end

endmodule

// File: doc/sme_rng_lanes.md
# sme_rng_lanes

Randomness source for the SME masked-arithmetic datapath: G independent 32-bit xorshift32 lanes that drive the `rng` guard-share input of the masked Kogge-Stone adder and DOM AND gadgets directly upstream. Lanes are seeded through a valid/ready handshake and pass through a fixed warm-up before `rng_valid` is raised. The consumer asserts `step` on every cycle it latches randomness, which is normally tied to the adder `en`, so no value is ever reused across two gadget cycles.

## Interface
- `D`, 3, number of shares.
- `G`, `D+D*(D-1)/2`, number of lanes (guard shares); must match the consumer.
- `N`, 32, lane width; 32 is the only supported value.
- `g_clk` in 1: global clock; the only clock.
- `g_reset` in 1: reset, synchronous and active-high.
- `g_clk_req` out 1: clock request; 1 in WARMUP or while `step`=1.
- `seed_valid` in 1: a seed is offered.
- `seed_ready` out 1: a seed can be accepted.
- `seed` in 32: seed word.
- `step` in 1: consumer used the current `rng`; advance all lanes.
- `rng[G-1:0]` out N each: lane outputs, equal to the lane state registers.
- `rng_valid` out 1: `rng` is usable.

## Operation
- States: UNSEEDED, WARMUP, READY, plus STALE when the reseed-limit feature is compiled in.
- Reset values:
  - state = UNSEEDED.
  - All lanes = 0, so every `rng[k]` = 0.
  - Warm-up counter = 0; step counter = 0.
  - `rng_valid` = 0.
- `seed_ready` = 1 in UNSEEDED, READY and STALE; 0 in WARMUP.
- Seed accept = `seed_valid` & `seed_ready`. On accept:
  - Lane k loads `seed ^ (k*32'h9E3779B9)`, computed mod 2^32.
  - A loaded value of 0 is replaced by 32'h00000001.
  - State goes to WARMUP, warm-up counter is cleared, step counter is cleared.
- Lane step is xorshift32 applied in order: `x^=x<<13; x^=x>>17; x^=x<<5`. All lanes step together.
- WARMUP:
  - Lanes step every cycle; `step` is ignored.
  - After 4 steps the state goes to READY.
- READY:
  - `rng_valid` = 1.
  - Lanes step on every cycle with `step`=1 and hold otherwise.
  - A seed accept may occur and returns the block to WARMUP.
- UNSEEDED:
  - `step` is ignored and lanes hold.
  - `rng_valid` = 0.
- Simultaneous seed accept and `step` in READY: the seed wins, the step is dropped, and the lanes load the new seed.
- `g_reset` at any point, including mid-WARMUP, returns the block to reset values on that edge.

## Timing
- Accept at edge E0: lanes hold the seeded values after E0.
- Edges E1..E4 each step the lanes.
- State = READY and `rng_valid` = 1 after E4.
- `rng` changes only on the edge following a cycle with `step`=1 (in READY), on warm-up edges, on a seed accept, or on reset.
- All outputs are registered or decoded from registered state only. There is no combinational path from `step` to `rng`. `g_clk_req` is the only output that depends combinationally on an input (`step`).
- Consumer contract: sample `rng` in the cycle `step` is high; the next value appears one cycle later.

## Configuration
- `SME_RNG_RESEED_LIMIT_EN` defined:
  - A 16-bit step counter increments on each accepted `step` in READY.
  - When the counter wraps from 16'hFFFF to 0 (the 65536th step), the state goes to STALE on that edge.
  - In STALE: `rng_valid` = 0, lanes frozen, `step` ignored, `seed_ready` = 1.
  - A seed accept in STALE goes to WARMUP and clears the counter.
- `SME_RNG_RESEED_LIMIT_EN` not defined:
  - No counter and no STALE state.
  - READY persists indefinitely, and lanes keep stepping until a reseed or reset.

## Test plan
- Reset, then seed=32'h00000001 accepted with G=6:
  - 1 cycle later `rng[0]`=32'h00000001, `rng[1]`=32'h9E3779B8, `rng_valid`=0.
  - Next cycle `rng[0]`=32'h00042021.
  - `rng_valid`=1 exactly 4 cycles after the accept.
- In READY, hold `step`=0 for 10 cycles: `rng` stays constant. Pulse `step` once: every lane advances by exactly one xorshift32 step versus a model.
- Seed=32'h9E3779B9 (lane 1 would load 0): `rng[1]`=32'h00000001 after the accept.
- `seed_valid` and `step` both high in READY: lanes reload from the new seed, `rng_valid` drops to 0 for 4 cycles, and `seed_ready`=0 during WARMUP.
- Assert `g_reset` during WARMUP cycle 2: after the edge all `rng`=0, `rng_valid`=0, state UNSEEDED, and `step` has no effect.
- With `SME_RNG_RESEED_LIMIT_EN`: after 65536 steps `rng_valid`=0 and lanes frozen; a new seed returns to READY 4 cycles after the accept. Without the macro, step 65537 still advances normally.
